// File: rtl/alu_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alu_scheduler
// Brief    : Round-robin arbiter sharing one combinational ALU between two
//            requesters; registered operands, captured result, done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module alu_scheduler #(
    parameter int NBITS_OPERADORES = 2,
    parameter int NBITS_F          = 3,
    parameter int NBITS_RESULTADO  = 2
) (
    input  logic                        clk_2,
    input  logic                        reset,
    input  logic                        req0,
    input  logic                        req1,
    input  logic [NBITS_OPERADORES-1:0] a0,
    input  logic [NBITS_OPERADORES-1:0] b0,
    input  logic [NBITS_F-1:0]          f0,
    input  logic [NBITS_OPERADORES-1:0] a1,
    input  logic [NBITS_OPERADORES-1:0] b1,
    input  logic [NBITS_F-1:0]          f1,
    output logic                        gnt0,
    output logic                        gnt1,
    output logic [NBITS_OPERADORES-1:0] alu_a,
    output logic [NBITS_OPERADORES-1:0] alu_b,
    output logic [NBITS_F-1:0]          alu_f,
    input  logic [NBITS_RESULTADO-1:0]  alu_y,
    output logic [NBITS_RESULTADO-1:0]  y,
    output logic                        done0,
    output logic                        done1,
    output logic                        err,
    output logic                        busy
);

    localparam logic [NBITS_F-1:0] F_UNSUP = NBITS_F'(3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic                        last;
    logic                        owner;
    logic                        unsup;
    logic                        take0;
    logic                        take1;
    logic                        fin;
    logic [NBITS_OPERADORES-1:0] sel_a;
    logic [NBITS_OPERADORES-1:0] sel_b;
    logic [NBITS_F-1:0]          sel_f;

    always_comb begin
        state_nx = state;
        take0    = 1'b0;
        take1    = 1'b0;
        fin      = 1'b0;
        case (state)
            IDLE: begin
                // Ties go to the requester that was not granted last.
                take0 = req0 & (~req1 | last);
                take1 = req1 & (~req0 | ~last);
                if (take0 | take1) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                fin      = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign sel_a = take1 ? a1 : a0;
    assign sel_b = take1 ? b1 : b0;
    assign sel_f = take1 ? f1 : f0;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
            owner <= 1'b0;
            unsup <= 1'b0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            err   <= 1'b0;
            alu_a <= '0;
            alu_b <= '0;
            alu_f <= '0;
            y     <= '0;
        end else begin
            state <= state_nx;
            gnt0  <= take0;
            gnt1  <= take1;
            done0 <= fin & ~owner;
            done1 <= fin & owner;
            err   <= fin & unsup;
            if (take0 | take1) begin
                last  <= take1;
                owner <= take1;
                alu_a <= sel_a;
                alu_b <= sel_b;
                // The unsupported code is accepted but never reaches the ALU.
                alu_f <= (sel_f == F_UNSUP) ? '0 : sel_f;
                unsup <= (sel_f == F_UNSUP);
            end
            if (fin) begin
                y <= unsup ? '0 : alu_y;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_scheduler
// Brief    : Scoreboard bench for alu_scheduler with a behavioural ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_scheduler;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [2:0] f0 = '0, f1 = '0;
    logic       gnt0, gnt1, done0, done1, err, busy;
    logic [1:0] alu_a, alu_b, alu_y, y;
    logic [2:0] alu_f;

    typedef struct packed {
        logic       owner;
        logic [1:0] yv;
        logic       ev;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_scheduler #(
        .NBITS_OPERADORES (2),
        .NBITS_F          (3),
        .NBITS_RESULTADO  (2)
    ) dut (
        .clk_2 (clk_2),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .a0    (a0),
        .b0    (b0),
        .f0    (f0),
        .a1    (a1),
        .b1    (b1),
        .f1    (f1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .alu_a (alu_a),
        .alu_b (alu_b),
        .alu_f (alu_f),
        .alu_y (alu_y),
        .y     (y),
        .done0 (done0),
        .done1 (done1),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk_2 = ~clk_2;

    // Behavioural ALU: and, or, add, -, and-not, or-not, sub, set-less-than.
    always_comb begin
        alu_y = 2'b00;
        case (alu_f)
            3'b000: alu_y = alu_a & alu_b;
            3'b001: alu_y = alu_a | alu_b;
            3'b010: alu_y = alu_a + alu_b;
            3'b100: alu_y = alu_a & ~alu_b;
            3'b101: alu_y = alu_a | ~alu_b;
            3'b110: alu_y = alu_a - alu_b;
            3'b111: alu_y = (alu_a < alu_b) ? 2'b01 : 2'b00;
            default: alu_y = 2'b00;
        endcase
    end

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk_2) begin
        if (done0 || done1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {done1, done0}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_owner", {done1, done0}, e.owner ? 2 : 1);
                check("result_y", y, e.yv);
                check("err_with_done", err, e.ev);
            end
        end else begin
            check("err_without_done", err, 0);
        end
    end

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic check_alu(input string tag, input int ea, input int eb, input int ef);
        check({tag, "_alu_a"}, alu_a, ea);
        check({tag, "_alu_b"}, alu_b, eb);
        check({tag, "_alu_f"}, alu_f, ef);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_gnt"}, {gnt1, gnt0}, 0);
        check({tag, "_done"}, {done1, done0}, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_y"}, y, 0);
        check_alu(tag, 0, 0, 0);
    endtask

    // One full operation starting in an IDLE cycle; returns in the next IDLE cycle.
    task automatic op(input string tag, input logic r, input logic [1:0] a,
                      input logic [1:0] b, input logic [2:0] f,
                      input logic [2:0] ef, input logic [1:0] ey, input logic ee);
        if (r) begin
            req1 = 1'b1; a1 = a; b1 = b; f1 = f;
        end else begin
            req0 = 1'b1; a0 = a; b0 = b; f0 = f;
        end
        sb.push_back('{owner: r, yv: ey, ev: ee});
        tick();
        check({tag, "_gnt"}, {gnt1, gnt0}, r ? 2 : 1);
        check({tag, "_busy_exec"}, busy, 1);
        check_alu(tag, a, b, ef);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        check({tag, "_gnt_pulse"}, {gnt1, gnt0}, 0);
        check({tag, "_busy_done"}, busy, 1);
        tick();
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_y_held"}, y, ey);
    endtask

    initial begin
        // Reset held two cycles with a pending request from requester 0.
        req0 = 1'b1; a0 = 2'd1; b0 = 2'd3; f0 = 3'b000;
        tick();
        check_cleared("rst1");
        tick();
        check_cleared("rst2");
        reset = 1'b0;
        sb.push_back('{owner: 1'b0, yv: 2'd1, ev: 1'b0});
        tick();
        check("post_rst_gnt", {gnt1, gnt0}, 1);
        check_alu("post_rst", 1, 3, 0);
        req0 = 1'b0;
        tick();
        tick();
        check("post_rst_y", y, 1);

        op("add_wrap", 1'b0, 2'd3, 2'd1, 3'b010, 3'b010, 2'd0, 1'b0);
        op("sub",      1'b1, 2'd1, 2'd2, 3'b110, 3'b110, 2'd3, 1'b0);
        op("slt",      1'b1, 2'd1, 2'd2, 3'b111, 3'b111, 2'd1, 1'b0);
        op("andn",     1'b1, 2'd3, 2'd1, 3'b100, 3'b100, 2'd2, 1'b0);

        // Round-robin with both requests held; last grant went to requester 1.
        req0 = 1'b1; a0 = 2'd2; b0 = 2'd1; f0 = 3'b010;
        req1 = 1'b1; a1 = 2'd2; b1 = 2'd3; f1 = 3'b000;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{owner: logic'(k % 2), yv: (k % 2) ? 2'd2 : 2'd3, ev: 1'b0});
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_gnt", {gnt1, gnt0}, (k % 2) ? 2 : 1);
            if (k % 2) check_alu("rr1", 2, 3, 0);
            else       check_alu("rr0", 2, 1, 2);
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            tick();
            check("rr_gap1", {gnt1, gnt0}, 0);
            tick();
            check("rr_gap2", {gnt1, gnt0}, 0);
        end
        check("rr_y_last", y, 2);

        // Reset in the EXEC cycle drops the operation.
        req0 = 1'b1; a0 = 2'd1; b0 = 2'd1; f0 = 3'b010;
        tick();
        check("midop_gnt", {gnt1, gnt0}, 1);
        reset = 1'b1;
        tick();
        check_cleared("midop");
        reset = 1'b0;
        a0 = 2'd2; b0 = 2'd3; f0 = 3'b001;
        sb.push_back('{owner: 1'b0, yv: 2'd3, ev: 1'b0});
        tick();
        check("midop_regnt", {gnt1, gnt0}, 1);
        check_alu("midop_regnt", 2, 3, 1);
        req0 = 1'b0;
        tick();
        tick();
        check("midop_y", y, 3);

        op("unsup", 1'b0, 2'd3, 2'd3, 3'b011, 3'b000, 2'd0, 1'b1);

        tick();
        tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/alu_scheduler.md
# alu_scheduler

Round-robin scheduler that shares the single combinational ALU (2-bit operands, 3-bit function code) between two requesters. It accepts one operation at a time through a req/gnt handshake and drives the ALU operand and function inputs from registered copies. It captures the ALU output into a result register and reports completion to the owning requester with a one-cycle done pulse. It sits in `top` between the switch/LCD-driven requesters and the ALU, replacing the direct SWI-to-ALU wiring.

## Interface
- NBITS_OPERADORES, 2, width of operands a/b
- NBITS_F, 3, width of function code f
- NBITS_RESULTADO, 2, width of ALU result y

- clk_2  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- req0, req1  in  1  operation request from requester 0 / 1; held high until gnt seen
- a0, b0, a1, b1  in  NBITS_OPERADORES  operands of requester 0 / 1
- f0, f1  in  NBITS_F  function code of requester 0 / 1
- gnt0, gnt1  out  1  one-cycle pulse: request accepted, operands latched
- alu_a, alu_b  out  NBITS_OPERADORES  registered operands driven to ALU
- alu_f  out  NBITS_F  registered function code driven to ALU
- alu_y  in  NBITS_RESULTADO  combinational ALU result
- y  out  NBITS_RESULTADO  captured result of last completed operation
- done0, done1  out  1  one-cycle pulse: y valid for requester 0 / 1
- err  out  1  pulses with done when accepted f was 011 (unsupported)
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, EXEC, DONE.
- **IDLE:**
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester not granted last (round-robin).
  - On grant: latch a/b/f of the winner into alu_a/alu_b/alu_f, set gnt of the winner, record the winner as last, go to EXEC.
- **EXEC:**
  - alu_* are stable. At the edge: y <= alu_y, done of the owner <= 1, go to DONE.
- **DONE:**
  - Clear done/err. Go to IDLE unconditionally.
  - Requests are not sampled in EXEC or DONE.
- **Unsupported f=011:**
  - The request is accepted normally (gnt issued).
  - alu_f is driven to 000 instead of 011.
  - y is forced to 0, and err pulses together with done.
- **Width rule:** results are truncated to NBITS_RESULTADO (modular 2-bit arithmetic). The scheduler does no arithmetic itself.
- **Ownership:** done and err go only to the owner recorded at grant, regardless of req levels during EXEC/DONE.
- **Requester duty:** drop req in the cycle after gnt. A req still high when the FSM returns to IDLE is treated as a new operation.
- **Reset:**
  - The FSM goes to IDLE.
  - last = 1, so requester 0 wins the first tie.
  - gnt0/1, done0/1, err, busy = 0; alu_a, alu_b, alu_f, y = 0.
- **Reset mid-operation:** any in-flight operation is dropped. No done is issued and y returns to 0.

## Timing
- Request high in IDLE cycle N (sampled at the end of N):
  - gnt high in cycle N+1; alu_* valid from N+1 onward.
  - done/err high in cycle N+2; y valid from N+2 and held until the next capture or reset.
  - FSM back in IDLE in cycle N+3.
- Maximum throughput is one operation per 3 cycles. Grant-to-done latency is 1 cycle.
- **busy:** high in cycles N+1 and N+2; low in IDLE.
- **Registered outputs:** gnt, done, err, y and alu_* are all registered, with no combinational path from req/a/b/f to outputs. busy decodes the state register.
- **Priority:** ties are decided solely by last. A lone requester is always granted, even if it was granted last.
- **alu_* hold:** alu_* keep the last issued operation while in IDLE.

## Test plan
- **Reset values:** assert reset for 2 cycles while req0=1 → all outputs 0, no gnt. Release → gnt0 exactly 1 cycle later.
- **Add with wrap:** req0, a0=3, b0=1, f0=010 → gnt0 at N+1, alu_a=3/alu_b=1/alu_f=010, done0 at N+2, y=00, err=0, done1 never.
- **Subtract / compare / and-not:**
  - req1, a1=1, b1=2, f1=110 → y=11, done1.
  - Then f1=111 → y=01.
  - Then a1=3, b1=1, f1=100 → y=10.
- **Round-robin:** req0 and req1 held high continuously → grants alternate 0,1,0,1, with consecutive grants exactly 3 cycles apart. Each y matches its owner's operands, and done goes to the matching requester.
- **Unsupported code:** req0, f0=011, a0=3, b0=3 → gnt0, alu_f=000, y=00, err and done0 together for one cycle.
- **Reset mid-op:** reset asserted in the EXEC cycle → next cycle state IDLE, done0 never pulses, y=0, busy=0. A request held through reset is granted 1 cycle after release.
